alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl
//
// Alarm-clock controller. Holds an hour/minute setpoint that is edited from
// the buttons in SET mode, starts ringing when the time of day reaches the
// setpoint (at second 0, alarm armed), and supports a limited number of
// snoozes per alarm event. Ringing stops automatically after RING_SECS
// seconds, on the stop button, or when the alarm is disarmed.
//
// Parameters
//   RING_SECS    seconds spent in RING before automatic stop
//   SNOOZE_SECS  seconds spent in SNOOZE before ringing again
//   MAX_SNOOZE   snoozes allowed per alarm event (must fit in 2 bits)
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   tick_1hz     one-cycle pulse per second
//   cur_hour     current hour   (0-23)
//   cur_min      current minute (0-59)
//   cur_sec      current second (0-59)
//   btn_p        one-cycle button pulses:
//                  [0] mode, [1] stop, [2] minute-inc / snooze, [3] hour-inc
//   sw_arm       alarm armed (level)
//   a_hour       alarm setpoint hour
//   a_min        alarm setpoint minute
//   state        IDLE=0, SET=1, RING=2, SNOOZE=3
//   buzz         buzzer drive, toggles once per second while ringing
//   ringing      high while in RING
//   snooze_left  snoozes remaining for the current alarm event
// ---------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [3:0] btn_p,
    input  logic       sw_arm,
    output logic [5:0] a_hour,
    output logic [5:0] a_min,
    output logic [1:0] state,
    output logic       buzz,
    output logic       ringing,
    output logic [1:0] snooze_left
);

    // Counter widths are derived from the parameters so the load values
    // always fit.
    localparam int RW = (RING_SECS   < 2) ? 1 : $clog2(RING_SECS + 1);
    localparam int SW = (SNOOZE_SECS < 2) ? 1 : $clog2(SNOOZE_SECS + 1);

    localparam logic [RW-1:0] RING_LD = RW'(RING_SECS);
    localparam logic [SW-1:0] SNZ_LD  = SW'(SNOOZE_SECS);
    localparam logic [1:0]    MAX_LD  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SET    = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    state_t          st;
    logic [RW-1:0]   ring_cnt;
    logic [SW-1:0]   snz_cnt;
    logic            match;
    logic            match_d;
    logic            trigger;

    logic            btn_mode;
    logic            btn_stop;
    logic            btn_min;
    logic            btn_hour;

    assign btn_mode = btn_p[0];
    assign btn_stop = btn_p[1];
    assign btn_min  = btn_p[2];
    assign btn_hour = btn_p[3];

    // The alarm fires on the rising edge of match only. match_d resets to 1
    // so that releasing reset during the matching second cannot re-trigger.
    assign match   = (cur_hour == a_hour) && (cur_min == a_min) && (cur_sec == 6'd0);
    assign trigger = sw_arm && match && !match_d;

    assign state   = st;
    assign ringing = (st == RING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            a_hour      <= 6'd0;
            a_min       <= 6'd0;
            buzz        <= 1'b0;
            match_d     <= 1'b1;
            snooze_left <= 2'd0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
        end else begin
            match_d <= match;

            case (st)
                IDLE: begin
                    if (trigger) begin
                        st          <= RING;
                        ring_cnt    <= RING_LD;
                        snooze_left <= MAX_LD;
                        buzz        <= 1'b1;
                    end else if (btn_mode) begin
                        st <= SET;
                    end
                end

                SET: begin
                    // Mode wins over any increment pulse in the same cycle;
                    // pressing both increments together is treated as a
                    // no-op rather than guessing which one was meant.
                    if (btn_mode) begin
                        st       <= IDLE;
                        ring_cnt <= '0;
                        snz_cnt  <= '0;
                        buzz     <= 1'b0;
                    end else if (btn_min && !btn_hour) begin
                        if (a_min >= 6'd59) begin
                            a_min <= 6'd0;
                            if (a_hour >= 6'd23) begin
                                a_hour <= 6'd0;
                            end else begin
                                a_hour <= a_hour + 6'd1;
                            end
                        end else begin
                            a_min <= a_min + 6'd1;
                        end
                    end else if (btn_hour && !btn_min) begin
                        if (a_hour >= 6'd23) begin
                            a_hour <= 6'd0;
                        end else begin
                            a_hour <= a_hour + 6'd1;
                        end
                    end
                end

                RING: begin
                    // Exit priority: disarm, stop, snooze, timeout.
                    if (!sw_arm || btn_stop) begin
                        st       <= IDLE;
                        ring_cnt <= '0;
                        snz_cnt  <= '0;
                        buzz     <= 1'b0;
                    end else if (btn_min) begin
                        if (snooze_left != 2'd0) begin
                            st          <= SNOOZE;
                            snz_cnt     <= SNZ_LD;
                            snooze_left <= snooze_left - 2'd1;
                            ring_cnt    <= '0;
                            buzz        <= 1'b0;
                        end else begin
                            // Out of snoozes: snooze behaves as stop.
                            st       <= IDLE;
                            ring_cnt <= '0;
                            snz_cnt  <= '0;
                            buzz     <= 1'b0;
                        end
                    end else if (tick_1hz) begin
                        if (ring_cnt <= RW'(1)) begin
                            // Last second elapsed: counter would reach 0.
                            st       <= IDLE;
                            ring_cnt <= '0;
                            snz_cnt  <= '0;
                            buzz     <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt - RW'(1);
                            buzz     <= ~buzz;
                        end
                    end
                end

                SNOOZE: begin
                    if (!sw_arm || btn_stop) begin
                        st       <= IDLE;
                        ring_cnt <= '0;
                        snz_cnt  <= '0;
                        buzz     <= 1'b0;
                    end else if (tick_1hz) begin
                        if (snz_cnt <= SW'(1)) begin
                            // Snooze over: ring again with a fresh ring
                            // period; the snooze budget is not restored.
                            st       <= RING;
                            snz_cnt  <= '0;
                            ring_cnt <= RING_LD;
                            buzz     <= 1'b1;
                        end else begin
                            snz_cnt <= snz_cnt - SW'(1);
                        end
                    end
                end

                default: begin
                    st       <= IDLE;
                    ring_cnt <= '0;
                    snz_cnt  <= '0;
                    buzz     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ctrl
//
// Self-checking bench for alarm_ctrl. A behavioural model keeps the alarm
// setpoint as minutes-of-day and the remaining ring/snooze time as plain
// integers; it is stepped with the same inputs each cycle and every DUT
// output is compared against it. Directed scenarios reproduce the typical
// use cases, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_alarm_ctrl;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic [5:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [3:0] btn_p;
    logic       sw_arm;
    logic [5:0] a_hour;
    logic [5:0] a_min;
    logic [1:0] state;
    logic       buzz;
    logic       ringing;
    logic [1:0] snooze_left;

    int n_checks;
    int n_fail;

    alarm_ctrl #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .btn_p      (btn_p),
        .sw_arm     (sw_arm),
        .a_hour     (a_hour),
        .a_min      (a_min),
        .state      (state),
        .buzz       (buzz),
        .ringing    (ringing),
        .snooze_left(snooze_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 set, 2 ring, 3 snooze
    int m_mode;
    int m_alarm;       // setpoint in minutes of day, 0..1439
    int m_prev_match;
    int m_ring_left;   // seconds of ringing remaining
    int m_snz_left;    // seconds of snooze remaining
    int m_snoozes;
    int m_buzz;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_alarm      = 0;
        m_prev_match = 1;
        m_ring_left  = 0;
        m_snz_left   = 0;
        m_snoozes    = 0;
        m_buzz       = 0;
    endtask

    task automatic model_to_idle();
        m_mode      = 0;
        m_ring_left = 0;
        m_snz_left  = 0;
        m_buzz      = 0;
    endtask

    task automatic model_step();
        int match;
        match = ((int'(cur_hour) * 60 + int'(cur_min)) == m_alarm) && (cur_sec == 0);
        case (m_mode)
            0: begin
                if (sw_arm && match && !m_prev_match) begin
                    m_mode      = 2;
                    m_ring_left = RING_SECS;
                    m_snoozes   = MAX_SNOOZE;
                    m_buzz      = 1;
                end else if (btn_p[0]) begin
                    m_mode = 1;
                end
            end
            1: begin
                if (btn_p[0])
                    model_to_idle();
                else if (btn_p[2] && !btn_p[3])
                    m_alarm = (m_alarm + 1) % 1440;
                else if (btn_p[3] && !btn_p[2])
                    m_alarm = (((m_alarm / 60) + 1) % 24) * 60 + (m_alarm % 60);
            end
            2: begin
                if (!sw_arm || btn_p[1]) begin
                    model_to_idle();
                end else if (btn_p[2]) begin
                    if (m_snoozes > 0) begin
                        m_mode      = 3;
                        m_snz_left  = SNOOZE_SECS;
                        m_snoozes   = m_snoozes - 1;
                        m_ring_left = 0;
                        m_buzz      = 0;
                    end else begin
                        model_to_idle();
                    end
                end else if (tick_1hz) begin
                    m_ring_left = m_ring_left - 1;
                    m_buzz      = !m_buzz;
                    if (m_ring_left == 0) model_to_idle();
                end
            end
            default: begin
                if (!sw_arm || btn_p[1]) begin
                    model_to_idle();
                end else if (tick_1hz) begin
                    m_snz_left = m_snz_left - 1;
                    if (m_snz_left == 0) begin
                        m_mode      = 2;
                        m_ring_left = RING_SECS;
                        m_buzz      = 1;
                    end
                end
            end
        endcase
        m_prev_match = match;
    endtask

    task automatic compare_all();
        check("state",       int'(state),       m_mode);
        check("a_hour",      int'(a_hour),      m_alarm / 60);
        check("a_min",       int'(a_min),       m_alarm % 60);
        check("buzz",        int'(buzz),        m_buzz);
        check("ringing",     int'(ringing),     (m_mode == 2) ? 1 : 0);
        check("snooze_left", int'(snooze_left), m_snoozes);
    endtask

    // One clock with the given buttons/tick; inputs change 1 time unit
    // after the rising edge, outputs are compared at the same point.
    task automatic cyc(input logic [3:0] b, input logic t);
        btn_p    = b;
        tick_1hz = t;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        btn_p    = 4'd0;
        tick_1hz = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 6'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    // Enter SET, program hh:mm from the current setpoint, leave SET.
    task automatic program_alarm(input int nh, input int nm);
        cyc(4'b0001, 1'b0);
        for (int i = 0; i < nh; i++) cyc(4'b1000, 1'b0);
        for (int i = 0; i < nm; i++) cyc(4'b0100, 1'b0);
        cyc(4'b0001, 1'b0);
    endtask

    // Generate a fresh rising edge of match at 07:30:00.
    task automatic fire_730();
        set_time(7, 29, 59);
        cyc(4'd0, 1'b0);
        set_time(7, 30, 0);
        cyc(4'd0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        btn_p    = 4'd0;
        sw_arm   = 1'b0;
        set_time(0, 0, 30);
        model_reset();
        #1;
        check("rst_state", int'(state), 0);
        check("rst_buzz",  int'(buzz),  0);
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'd0, 1'b0);

        // Program 07:30 and fire the alarm
        program_alarm(7, 30);
        check("set730_hour",  int'(a_hour), 7);
        check("set730_min",   int'(a_min),  30);
        check("set730_state", int'(state),  0);
        sw_arm = 1'b1;
        fire_730();
        check("fire_state", int'(state), 2);
        check("fire_buzz",  int'(buzz),  1);
        check("fire_snz",   int'(snooze_left), MAX_SNOOZE);

        // Ring to timeout; buzz toggles each tick
        for (int i = 0; i < RING_SECS; i++) begin
            cyc(4'd0, 1'b1);
            if (i < RING_SECS - 1) begin
                check("ring_alive", int'(state), 2);
                check("ring_buzz", int'(buzz), (i % 2 == 0) ? 0 : 1);
            end
            cyc(4'd0, 1'b0);
        end
        check("timeout_state", int'(state), 0);
        check("timeout_buzz",  int'(buzz),  0);
        for (int s = 0; s < 20; s++) cyc(4'd0, 1'b0);
        check("no_retrig_same_sec", int'(state), 0);
        for (int s = 1; s < 60; s++) begin
            set_time(7, 30, s);
            cyc(4'd0, 1'b1);
        end
        check("no_retrig_minute", int'(state), 0);

        // Snooze three times, then a fourth snooze acts as stop
        fire_730();
        check("snz_fire", int'(state), 2);
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            cyc(4'b0100, 1'b0);
            check("snz_enter", int'(state), 3);
            check("snz_left",  int'(snooze_left), MAX_SNOOZE - 1 - k);
            check("snz_buzz",  int'(buzz), 0);
            for (int i = 0; i < SNOOZE_SECS; i++) cyc(4'd0, 1'b1);
            check("snz_rering", int'(state), 2);
        end
        check("snz_exhausted", int'(snooze_left), 0);
        cyc(4'b0100, 1'b0);
        check("snz_4th_stop", int'(state), 0);

        // Stop + snooze together -> stop wins
        fire_730();
        cyc(4'b0110, 1'b0);
        check("stop_snz_state", int'(state), 0);

        // Disarm during snooze
        fire_730();
        cyc(4'b0100, 1'b0);
        check("disarm_pre", int'(state), 3);
        sw_arm = 1'b0;
        cyc(4'd0, 1'b0);
        check("disarm_state", int'(state), 0);
        check("disarm_buzz",  int'(buzz),  0);
        sw_arm = 1'b1;

        // Setpoint wrap at 23:59 and simultaneous increments
        cyc(4'b0001, 1'b0);
        for (int i = 0; i < 16; i++) cyc(4'b1000, 1'b0);
        for (int i = 0; i < 29; i++) cyc(4'b0100, 1'b0);
        check("pre_wrap_hour", int'(a_hour), 23);
        check("pre_wrap_min",  int'(a_min),  59);
        cyc(4'b0100, 1'b0);
        check("wrap_hour", int'(a_hour), 0);
        check("wrap_min",  int'(a_min),  0);
        cyc(4'b1100, 1'b0);
        check("both_inc_hour", int'(a_hour), 0);
        check("both_inc_min",  int'(a_min),  0);
        cyc(4'b1000, 1'b0);
        check("hour_inc", int'(a_hour), 1);
        cyc(4'b1101, 1'b0);
        check("mode_prio_state", int'(state), 0);
        check("mode_prio_hour",  int'(a_hour), 1);

        // Asynchronous reset mid-ring
        program_alarm(6, 30);
        check("reprog_hour", int'(a_hour), 7);
        check("reprog_min",  int'(a_min),  30);
        fire_730();
        check("rst_pre_ring", int'(state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_state", int'(state),  0);
        check("async_rst_hour",  int'(a_hour), 0);
        check("async_rst_min",   int'(a_min),  0);
        check("async_rst_buzz",  int'(buzz),   0);
        set_time(0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(4'd0, 1'b1);
        check("post_rst_no_ring", int'(state), 0);
        set_time(7, 30, 0);
        for (int i = 0; i < 5; i++) cyc(4'd0, 1'b0);
        check("post_rst_730", int'(state), 0);

        // Randomized phase
        for (int n = 0; n < 6000; n++) begin
            logic [3:0] b;
            b = 4'd0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 9) == 0) b[k] = 1'b1;
            if ($urandom_range(0, 79) == 0) sw_arm = ~sw_arm;
            case ($urandom_range(0, 3))
                0: set_time(m_alarm / 60, m_alarm % 60, 0);
                1: set_time(m_alarm / 60, m_alarm % 60, $urandom_range(1, 59));
                2: set_time($urandom_range(0, 23), $urandom_range(0, 59), 0);
                default: ;
            endcase
            cyc(b, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
